shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: DONE_HOLD, default 0. 0: done is a one-cycle pulse. 1: done is held high until the next accepted start.
REQ-002 Port: clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port: start, input, 1, request strobe; sampled only in IDLE.
REQ-005 Port: op, input, 2, operation code: 00 SLL, 01 SRL, 10 SRA, 11 LUI.
REQ-006 Port: shamt, input, 5, shift amount; ignored for LUI.
REQ-007 Port: a, input, 32, operand; LUI uses a[15:0] only.
REQ-008 Port: busy, output, 1, high in SHIFT and DONE states.
REQ-009 Port: done, output, 1, result-valid indication.
REQ-010 Port: result, output, 32, shifted value.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 Transition when start=1 in IDLE: capture op, shamt and a into internal registers.
  - If the effective amount is nonzero, go to SHIFT.
  - If it is zero, go directly to DONE.
REQ-013 Effective amount SHALL be shamt for SLL, SRL and SRA, and 5'b10000 for LUI; for LUI the working register loads {16'b0, a[15:0]}.
REQ-014 In SHIFT, each cycle SHALL apply exactly one stage: the largest remaining set bit of the amount, in the order 16, 8, 4, 2, 1.
  - That bit is then cleared.
  - When no set bits remain, go to DONE.
REQ-015 Stage semantics:
  - SLL and LUI: zero-fill from the right.
  - SRL: zero-fill from the left.
  - SRA: fill with the captured a[31].
REQ-016 Latency: with start accepted at edge N, done SHALL assert after edge N+1+k, where k = popcount of the effective amount (0..5).
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE; busy is low in IDLE.
REQ-018 In DONE, result SHALL equal the full shift.
  - result is held stable until the next accepted start.
  - result does not change during SHIFT; shifting uses an internal working register.
REQ-019 start while busy SHALL be ignored; there is no queueing.
REQ-020 start in the same cycle that DONE occurs SHALL be ignored; the earliest accepted start is in the following IDLE cycle.
REQ-021 Input changes after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, busy=0, done=0, result=32'h0, and all internal registers to 0.
REQ-023 Reset during SHIFT or DONE SHALL abandon the operation; no done is produced.
REQ-024 After rst_n deasserts, start is accepted on the first rising edge.

Configuration
REQ-025 Macro SHIFT_SEQ_SRA_EN defined: op=10 SHALL perform arithmetic right shift per REQ-015.
REQ-026 Macro SHIFT_SEQ_SRA_EN undefined: op=10 SHALL behave exactly as SRL, with zero-fill.
REQ-027 Latency and handshake SHALL be identical with and without the macro.

Verification
REQ-028 Reset: rst_n=0, then release -> busy=0, done=0, result=32'h00000000.
REQ-029 LUI: op=11, a=32'hFFFF1234, start -> done one cycle after SHIFT (k=1, done after edge N+2), result=32'h12340000.
REQ-030 SLL: op=00, shamt=5'd31, a=32'h00000001 -> five SHIFT cycles, done after edge N+6, result=32'h80000000.
REQ-031 SRA: op=10, shamt=5'd4, a=32'hF0000000 -> result=32'hFF000000 with the macro defined; 32'h0F000000 without it.
REQ-032 Zero amount and ignored start: op=01, shamt=0, a=32'hA5A5A5A5 -> done after edge N+1, result=32'hA5A5A5A5. Then assert start while busy -> ignored, result unchanged.
REQ-033 Reset mid-operation: op=00, shamt=5'd21, start; assert rst_n=0 in the second SHIFT cycle -> immediate IDLE, done never asserted, result=32'h0. Run both DONE_HOLD=0 and DONE_HOLD=1.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Sequential barrel shifter: one power-of-two stage per cycle (16,8,4,2,1), SLL/SRL/SRA/LUI.
// Define SHIFT_SEQ_SRA_EN for arithmetic right shift on op=10; otherwise op=10 acts as SRL.
module shift_seq_ctrl #(
  parameter int DONE_HOLD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

`ifdef SHIFT_SEQ_SRA_EN
  localparam bit SRA_EN = 1'b1;
`else
  localparam bit SRA_EN = 1'b0;
`endif

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_LUI = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg;
  logic [1:0]  op_reg;
  logic [4:0]  amt_reg;
  logic [31:0] work_reg;
  logic        fill_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [31:0] result_reg;

  logic [4:0]  eff_amt;
  logic [31:0] eff_a;
  logic        eff_fill;
  logic [4:0]  stage_sh;
  logic [4:0]  amt_next;
  logic [31:0] fill_mask;
  logic [31:0] stage_val;

  always_comb begin
    eff_amt  = (op == OP_LUI) ? 5'b10000 : shamt;
    eff_a    = (op == OP_LUI) ? {16'h0000, a[15:0]} : a;
    eff_fill = SRA_EN && (op == OP_SRA) && a[31];
  end

  // Scan upward so the highest set bit wins; that bit is the stage applied this cycle.
  always_comb begin
    stage_sh = 5'd0;
    amt_next = amt_reg;
    for (int i = 0; i < 5; i++) begin
      if (amt_reg[i]) begin
        stage_sh = 5'(1 << i);
        amt_next = amt_reg & ~(5'(1 << i));
      end
    end
    fill_mask = fill_reg ? ~(32'hFFFF_FFFF >> stage_sh) : 32'h0;
    if (op_reg == OP_SLL || op_reg == OP_LUI)
      stage_val = work_reg << stage_sh;
    else
      stage_val = (work_reg >> stage_sh) | fill_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= 2'b00;
      amt_reg    <= 5'd0;
      work_reg   <= 32'h0;
      fill_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (DONE_HOLD == 0)
            done_reg <= 1'b0;
          if (start) begin
            done_reg <= 1'b0;
            op_reg   <= op;
            amt_reg  <= eff_amt;
            work_reg <= eff_a;
            fill_reg <= eff_fill;
            busy_reg <= 1'b1;
            if (eff_amt == 5'd0) begin
              state_reg  <= DONE;
              result_reg <= eff_a;
            end else begin
              state_reg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_reg <= stage_val;
          amt_reg  <= amt_next;
          if (amt_next == 5'd0) begin
            state_reg  <= DONE;
            result_reg <= stage_val;
          end
        end
        DONE: begin
          // done is registered off the DONE state, so it shows one cycle later.
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl; runs DONE_HOLD=0 and DONE_HOLD=1 instances side by side.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic        busy0, done0, busy1, done1;
  logic [31:0] result0, result1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prev_res;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.DONE_HOLD(0)) u_pulse (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shamt(shamt), .a(a),
    .busy(busy0), .done(done0), .result(result0)
  );

  shift_seq_ctrl #(.DONE_HOLD(1)) u_hold (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shamt(shamt), .a(a),
    .busy(busy1), .done(done1), .result(result1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [4:0] s, input logic [31:0] av);
    exp_t e;
    case (o)
      2'b00: begin e.res = av << s; e.lat = 1 + $countones(s); end
      2'b01: begin e.res = av >> s; e.lat = 1 + $countones(s); end
`ifdef SHIFT_SEQ_SRA_EN
      2'b10: begin e.res = $signed(av) >>> s; e.lat = 1 + $countones(s); end
`else
      2'b10: begin e.res = av >> s; e.lat = 1 + $countones(s); end
`endif
      default: begin e.res = {av[15:0], 16'h0000}; e.lat = 2; end
    endcase
    return e;
  endfunction

  // Called at a negedge with the DUTs idle; poke raises start again one cycle after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] av, input bit poke);
    exp_t e;
    exp_t x;
    int   c;
    bit   seen;
    e = model(o, s, av);
    sb.push_back(e);
    op = o; shamt = s; a = av; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy_accept", {31'b0, busy0}, 32'd1);
    check("done_accept", {30'b0, done0, done1}, 32'd0);
    if (e.lat > 1) check("result_hold_first", result0, prev_res);
    op = 2'($urandom); shamt = 5'($urandom); a = $urandom; start = poke;
    c = 0;
    seen = 1'b0;
    while (!seen && c <= 20) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      start = 1'b0;
      if (done0) begin
        x = sb.pop_front();
        check("latency", c, x.lat);
        check("result", result0, x.res);
        check("result_hold_inst", result1, x.res);
        check("done_hold_inst", {31'b0, done1}, 32'd1);
        check("busy_at_done", {31'b0, busy0}, 32'd0);
        seen = 1'b1;
      end else begin
        check("busy_pending", {31'b0, busy0}, 32'd1);
        check("done_hold_early", {31'b0, done1}, 32'd0);
        if (c < e.lat - 1) check("result_hold_shift", result0, prev_res);
      end
    end
    if (!seen) begin
      check("timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    prev_res = e.res;
    @(posedge clk);
    @(negedge clk);
    check("done_pulse_end", {31'b0, done0}, 32'd0);
    check("done_hold_stays", {31'b0, done1}, 32'd1);
    check("busy_idle", {31'b0, busy0}, 32'd0);
    check("result_stable", result0, prev_res);
    $display("op=%b shamt=%0d a=%h -> result=%h lat=%0d", o, s, av, result0, c);
  endtask

  task automatic reset_mid_op();
    op = 2'b00; shamt = 5'd21; a = $urandom | 32'h1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {30'b0, busy0, busy1}, 32'd0);
    check("rst_done", {30'b0, done0, done1}, 32'd0);
    check("rst_result_pulse", result0, 32'h0);
    check("rst_result_hold", result1, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      check("rst_no_done", {30'b0, done0, done1}, 32'd0);
    end
    prev_res = 32'h0;
    $display("reset mid-op: busy=%b done=%b result=%h", busy0, done0, result0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; shamt = 5'd0; a = 32'h0;
    prev_res = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", {30'b0, busy0, busy1}, 32'd0);
    check("reset_done", {30'b0, done0, done1}, 32'd0);
    check("reset_result", result0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_result", result1, 32'h0);
    check("post_reset_busy", {31'b0, busy0}, 32'd0);

    run_op(2'b11, 5'd7,  32'hFFFF1234, 1'b0);
    run_op(2'b00, 5'd31, 32'h00000001, 1'b1);
    run_op(2'b10, 5'd4,  32'hF0000000, 1'b0);
    run_op(2'b01, 5'd0,  32'hA5A5A5A5, 1'b1);
    run_op(2'b10, 5'd31, 32'h80000000, 1'b1);
    run_op(2'b00, 5'd0,  32'h12345678, 1'b0);
    for (int i = 0; i < 8; i++)
      run_op(2'($urandom), 5'($urandom), $urandom, i[0]);

    reset_mid_op();
    run_op(2'b11, 5'd0, 32'h0000BEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
